seg_scan_ctrl: RTL

Scan scheduler and frame-buffer controller for the 8-digit common-anode seven-segment display. It owns digit sequencing, per-digit dwell and anti-ghost blanking timing, hex-to-segment encoding and a double-buffered digit store. Producers write into a shadow buffer over a valid/ready port and request a commit; the controller swaps the buffer only at a frame boundary, so the display never shows a torn frame. It replaces the free-running divider/counter/decoder chain at the top of the display path.

---
 rtl/seg_scan_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit seven-segment scan scheduler with double-buffered digit store
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_valid/wr_ready   shadow write handshake; wr_addr selects digit, wr_data/wr_dp the content
//   commit              request copy of shadow to active at the next frame boundary
//   digit_en            per-digit enable, 0 blanks that digit's slot
//   commit_done         pulses with frame_start when a copy has taken place
//   frame_start         pulses as digit 0's slot appears on the outputs
//   AN, SEG             active-low anode selects and segments (SEG[7] = DP)
module seg_scan_ctrl #(
  parameter int DWELL = 100000,
  parameter int BLANK = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_dp,
  input  logic       commit,
  input  logic [7:0] digit_en,
  output logic       commit_done,
  output logic       frame_start,
  output logic [7:0] AN,
  output logic [7:0] SEG
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {ST_SCAN, ST_BLANK} state_t;

  state_t        state;
  logic [2:0]    digit;
  logic [CW-1:0] cnt;
  logic          pending;
  logic [4:0]    shadow [8];
  logic [4:0]    active [8];

  logic          boundary;
  logic          copy;
  logic [4:0]    src;

  function automatic logic [6:0] enc7(input logic [3:0] h);
    case (h)
      4'h0: enc7 = 7'h40;
      4'h1: enc7 = 7'h79;
      4'h2: enc7 = 7'h24;
      4'h3: enc7 = 7'h30;
      4'h4: enc7 = 7'h19;
      4'h5: enc7 = 7'h12;
      4'h6: enc7 = 7'h02;
      4'h7: enc7 = 7'h78;
      4'h8: enc7 = 7'h00;
      4'h9: enc7 = 7'h10;
      4'hA: enc7 = 7'h08;
      4'hB: enc7 = 7'h03;
      4'hC: enc7 = 7'h46;
      4'hD: enc7 = 7'h21;
      4'hE: enc7 = 7'h06;
      default: enc7 = 7'h0E;
    endcase
  endfunction

  // The first cycle of digit 0's SCAN is the frame boundary; the copy is
  // made at the edge closing it, so the registered SEG for that edge must
  // already take the freshly committed shadow entry.
  assign boundary = (state == ST_SCAN) && (digit == 3'd0) && (cnt == '0);
  assign copy     = boundary && pending;
  assign src      = copy ? shadow[digit] : active[digit];

  // Held low during commit_done so a stalled write lands the cycle after it.
  assign wr_ready = rst_n & ~pending & ~commit_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_SCAN;
      digit       <= 3'd0;
      cnt         <= '0;
      pending     <= 1'b0;
      AN          <= 8'hFF;
      SEG         <= 8'hFF;
      frame_start <= 1'b0;
      commit_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= 5'd0;
        active[i] <= 5'd0;
      end
    end else begin
      case (state)
        ST_SCAN: begin
          if (cnt == CW'(DWELL - 1)) begin
            cnt <= '0;
            if (BLANK == 0) digit <= digit + 3'd1;
            else            state <= ST_BLANK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CW'(BLANK - 1)) begin
            cnt   <= '0;
            state <= ST_SCAN;
            digit <= digit + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      if ((state == ST_SCAN) && digit_en[digit]) begin
        AN  <= ~(8'b1 << digit);
        SEG <= {~src[4], enc7(src[3:0])};
      end else begin
        AN  <= 8'hFF;
        SEG <= 8'hFF;
      end

      frame_start <= boundary;
      commit_done <= copy;

      if (copy) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow[i];
      end

      // A commit seen while a copy is being made is dropped with the old pending.
      if (copy)        pending <= 1'b0;
      else if (commit) pending <= 1'b1;

      if (wr_valid && wr_ready) shadow[wr_addr] <= {wr_dp, wr_data};
    end
  end

endmodule
